// File: rtl/fft_bitrev_loader.sv
// ----------------------------------------------------------------------------
// fft_bitrev_loader
//
// Input stage of the radix-2 FFT engine. One frame of N complex samples is
// accepted in natural order and written into a single-bank buffer at the
// bit-reversed address. The buffer is then replayed in address order, so the
// butterfly stage downstream sees a decimation-in-time ordered frame. Load and
// drain phases alternate and never overlap.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   input sample valid
//   in_ready   block can accept an input sample (LOAD phase, not in reset)
//   in_data    complex sample {real[2*DW-1:DW], imag[DW-1:0]}
//   in_last    final sample of an input frame
//   out_valid  output sample valid (DRAIN phase, not in reset)
//   out_ready  downstream can accept an output sample
//   out_data   complex sample, same packing as in_data
//   out_idx    buffer position of out_data
//   out_last   high with the final output sample of a frame
//   frame_err  one-cycle pulse after a handshake that broke the framing
//
// State table
//   state | meaning
//   LOAD  | accepting samples, writing mem[bitrev(wr_cnt)]
//   DRAIN | presenting mem[rd_cnt] to the butterfly, rd_cnt = 0..N-1
// ----------------------------------------------------------------------------
module fft_bitrev_loader #(
    parameter int  N          = 16,
    parameter int  DATA_WIDTH = 8,
    localparam int CMD_WIDTH  = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [CMD_WIDTH-1:0]    out_idx,
    output logic                    out_last,
    output logic                    frame_err
);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [CMD_WIDTH-1:0] LAST_IDX = CMD_WIDTH'(N - 1);

    state_t                    state;
    logic [CMD_WIDTH-1:0]      wr_cnt;
    logic [CMD_WIDTH-1:0]      rd_cnt;
    logic [2*DATA_WIDTH-1:0]   mem [N];
    logic                      in_fire;
    logic                      out_fire;

    function automatic logic [CMD_WIDTH-1:0] bitrev(input logic [CMD_WIDTH-1:0] a);
        logic [CMD_WIDTH-1:0] r;
        for (int i = 0; i < CMD_WIDTH; i++) begin
            r[i] = a[CMD_WIDTH-1-i];
        end
        return r;
    endfunction

    // Handshake qualifiers are gated by rst so nothing moves while reset is held.
    assign in_ready  = (state == LOAD) && !rst;
    assign out_valid = (state == DRAIN) && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_data  = mem[rd_cnt];
    assign out_idx   = rd_cnt;
    assign out_last  = out_valid && (rd_cnt == LAST_IDX);

    // Buffer is deliberately not reset: a reset only abandons the frame, and
    // nothing is presented from the buffer until a complete frame is loaded.
    // A frame that ends in a framing error may have partially overwritten the
    // buffer; that is harmless because it is never drained.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[bitrev(wr_cnt)] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt <= '0;
                            if (in_last) begin
                                state <= DRAIN;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            // Early in_last: drop the short frame and realign.
                            wr_cnt    <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (rd_cnt == LAST_IDX) begin
                            rd_cnt <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // Phases never overlap, and a stalled output must not change underneath
    // the butterfly.
    a_phase_exclusive: assert property (@(posedge clk) !(in_ready && out_valid));

    a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_idx) && $stable(out_data) && $stable(out_last)));

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// ----------------------------------------------------------------------------
// tb_fft_bitrev_loader
//
// Randomised bench for fft_bitrev_loader (N=16, DATA_WIDTH=8). A driver
// issues frames; an input-side observer feeds a frame-level reference model
// that, on each complete frame, pushes the expected reordered output into a
// scoreboard queue. The output monitor compares every presented output
// against the queue head and pops it on handshake. Phase (load/drain),
// frame_err timing and reset behaviour are checked against the model too.
// ----------------------------------------------------------------------------
module tb_fft_bitrev_loader;

    localparam int N   = 16;
    localparam int DW  = 8;
    localparam int LOG = $clog2(N);

    typedef struct {
        logic [2*DW-1:0] data;
        int              idx;
        bit              last;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_data;
    logic [LOG-1:0]  out_idx;
    logic            out_last;
    logic            frame_err;

    fft_bitrev_loader #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t            sb[$];
    logic [2*DW-1:0] cur[$];
    bit              m_drain  = 1'b0;
    bit              err_pend = 1'b0;
    int              drain_hs = 0;
    int              rdy_mode = 0;
    int              pat_i    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit reversal by plain arithmetic: peel low digits off p, push them onto r.
    function automatic int rev(input int p);
        int r = 0;
        int x = p;
        for (int i = 0; i < LOG; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [2*DW-1:0] mk(input int v);
        logic [DW-1:0] re;
        re = v[DW-1:0];
        return {re, DW'(0) - re};
    endfunction

    // Reference model + scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        check("frame_err", frame_err, err_pend);
        err_pend = 1'b0;
        if (rst) begin
            check("in_ready_in_rst", in_ready, 0);
            check("out_valid_in_rst", out_valid, 0);
            sb.delete();
            cur.delete();
            m_drain = 1'b0;
        end else begin
            check("in_ready", in_ready, !m_drain);
            check("out_valid", out_valid, m_drain);
            if (m_drain && out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 0, 1);
                end else begin
                    e = sb[0];
                    check("out_data", out_data, e.data);
                    check("out_idx", out_idx, e.idx);
                    check("out_last", out_last, e.last);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        drain_hs++;
                        if (sb.size() == 0) m_drain = 1'b0;
                    end
                end
            end else if (!m_drain && in_valid) begin
                cur.push_back(in_data);
                if (in_last && cur.size() == N) begin
                    for (int p = 0; p < N; p++) begin
                        e.data = cur[rev(p)];
                        e.idx  = p;
                        e.last = (p == N - 1);
                        sb.push_back(e);
                    end
                    m_drain = 1'b1;
                    cur.delete();
                end else if (in_last || cur.size() == N) begin
                    err_pend = 1'b1;
                    cur.delete();
                end
            end
        end
    end

    // out_ready generator: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       begin out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic send_sample(input logic [2*DW-1:0] d, input logic l, input int gap);
        bit ok = 1'b0;
        int t  = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!ok && t < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    // kind 0: real=base+k, imag=-(base+k); kind 1: random samples.
    task automatic send_frame(input int kind, input int base, input int cnt,
                              input int last_at, input bit gaps);
        logic [31:0] r;
        for (int k = 0; k < cnt; k++) begin
            r = $urandom();
            send_sample(kind == 0 ? mk(base + k) : r[2*DW-1:0], k == last_at,
                        gaps ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic idle(input int cyc);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (m_drain && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (m_drain) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int t;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Natural ramp, always ready, then with 1,0,0,1 backpressure.
        rdy_mode = 0;
        send_frame(0, 0, N, N - 1, 0);
        idle(0);
        wait_drain();
        rdy_mode = 1;
        pat_i    = 0;
        send_frame(0, 0, N, N - 1, 0);
        idle(0);
        wait_drain();

        // Early in_last on sample 5, then a clean frame 100..115.
        rdy_mode = 0;
        send_frame(0, 50, 6, 5, 0);
        idle(3);
        send_frame(0, 100, N, N - 1, 0);
        idle(0);
        wait_drain();

        // Full-length frame without in_last.
        send_frame(0, 20, N, -1, 0);
        idle(5);

        // Reset after three drain handshakes, then a fresh frame.
        send_frame(0, 30, N, N - 1, 0);
        idle(0);
        base = drain_hs;
        t    = 0;
        while (drain_hs < base + 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_hs_before_rst", drain_hs, base + 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(1, 0, N, N - 1, 0);
        idle(0);
        wait_drain();

        // Back-to-back frames with in_valid held high through the drain.
        send_frame(0, 60, N, N - 1, 0);
        send_frame(1, 0, N, N - 1, 0);
        idle(0);
        wait_drain();

        // Random frames, random gaps, random backpressure.
        rdy_mode = 2;
        for (int f = 0; f < 6; f++) begin
            send_frame(1, 0, N, N - 1, 1);
        end
        idle(0);
        wait_drain();
        idle(4);

        check("sb_empty_at_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
